// File: rtl/corr_pkg.sv
// corr_pkg: shared constants and entry layout for the correlation window buffer.
//   CORR_DATA_W  - default width of each count field
//   CORR_DEPTH_W - default log2 of the FIFO depth
//   CORR_SEQ_W   - default width of the window sequence number / drop counter
//   CORR_ENTRY_W - packed entry width at default widths
//   corr_entry_t - packed entry {seq, count_symdiff, count_isect, count_y, count_x}
package corr_pkg;

  localparam int unsigned CORR_DATA_W  = 8;
  localparam int unsigned CORR_DEPTH_W = 2;
  localparam int unsigned CORR_SEQ_W   = 8;
  localparam int unsigned CORR_ENTRY_W = CORR_SEQ_W + 4 * CORR_DATA_W;

  // MSB-first layout; count_x occupies the low bits.
  typedef struct packed {
    logic [CORR_SEQ_W-1:0]  seq;
    logic [CORR_DATA_W-1:0] count_symdiff;
    logic [CORR_DATA_W-1:0] count_isect;
    logic [CORR_DATA_W-1:0] count_y;
    logic [CORR_DATA_W-1:0] count_x;
  } corr_entry_t;

endpackage

// File: rtl/corr_window_fifo_mem.sv
// corr_window_fifo_mem: 2**DEPTH_W x WIDTH storage, one registered write port and
// one asynchronous read port. Contents are not reset.
//   clk_i   - clock
//   we_i    - write enable (already qualified by the clock gate)
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address
//   rdata_o - combinational read data
module corr_window_fifo_mem #(
  parameter int unsigned DEPTH_W = 2,
  parameter int unsigned WIDTH   = 40
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [DEPTH_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic [DEPTH_W-1:0] raddr_i,
  output logic [WIDTH-1:0]   rdata_o
);

  localparam int unsigned Depth = 1 << DEPTH_W;

  logic [WIDTH-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/corr_window_buffer.sv
// corr_window_buffer: snapshots the four window counts at every window boundary into a
// first-word-fall-through FIFO, tagging each entry with a window sequence number.
// The first boundary after reset closes a partial window and is discarded.
//   i_clk, i_rst        - clock, asynchronous active-high reset
//   i_cg                - clock-gate enable; all state holds when low
//   i_tUpdate           - window-boundary strobe
//   i_count*            - live window counts
//   o_valid / i_ready   - head entry handshake
//   o_count*, o_seq     - head entry contents
//   o_level             - FIFO occupancy
//   o_overflow          - sticky drop flag
//   o_nDropped          - saturating drop count
//   i_clrOverflow       - clears o_overflow and o_nDropped
module corr_window_buffer import corr_pkg::*; #(
  parameter int unsigned DATA_W  = CORR_DATA_W,
  parameter int unsigned DEPTH_W = CORR_DEPTH_W,
  parameter int unsigned SEQ_W   = CORR_SEQ_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cg,
  input  logic               i_tUpdate,
  input  logic [DATA_W-1:0]  i_countX,
  input  logic [DATA_W-1:0]  i_countY,
  input  logic [DATA_W-1:0]  i_countIsect,
  input  logic [DATA_W-1:0]  i_countSymdiff,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DATA_W-1:0]  o_countX,
  output logic [DATA_W-1:0]  o_countY,
  output logic [DATA_W-1:0]  o_countIsect,
  output logic [DATA_W-1:0]  o_countSymdiff,
  output logic [SEQ_W-1:0]   o_seq,
  output logic [DEPTH_W:0]   o_level,
  output logic               o_overflow,
  output logic [SEQ_W-1:0]   o_nDropped,
  input  logic               i_clrOverflow
);

  localparam int unsigned EntryW = SEQ_W + 4 * DATA_W;

  logic [DEPTH_W:0]   level_q, level_d;
  logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic               primed_q, primed_d;
  logic               overflow_q, overflow_d;
  logic [SEQ_W-1:0]   n_dropped_q, n_dropped_d;

  logic              snap, push_evt, pop, full, store, drop, clr;
  logic [EntryW-1:0] wdata, rdata;

  assign snap     = i_cg & i_tUpdate;
  assign push_evt = snap & primed_q;
  assign pop      = i_cg & o_valid & i_ready;
  // Occupancy never exceeds the depth, so the MSB alone marks full.
  assign full     = level_q[DEPTH_W];
  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign store    = push_evt & (~full | pop);
  assign drop     = push_evt & full & ~pop;
  assign clr      = i_cg & i_clrOverflow;

  assign wdata = {seq_q, i_countSymdiff, i_countIsect, i_countY, i_countX};

  corr_window_fifo_mem #(
    .DEPTH_W (DEPTH_W),
    .WIDTH   (EntryW)
  ) u_mem (
    .clk_i   (i_clk),
    .we_i    (store),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  always_comb begin
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    seq_d    = seq_q;
    primed_d = primed_q;

    if (store && !pop) begin
      level_d = level_q + (DEPTH_W + 1)'(1);
    end else if (pop && !store) begin
      level_d = level_q - (DEPTH_W + 1)'(1);
    end
    if (store) begin
      wr_ptr_d = wr_ptr_q + DEPTH_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_W'(1);
    end
    // Sequence advances on every primed snapshot, stored or dropped, so drops show as gaps.
    if (push_evt) begin
      seq_d = seq_q + SEQ_W'(1);
    end
    if (snap) begin
      primed_d = 1'b1;
    end
  end

  // Clear is applied first so a simultaneous drop still registers as one drop.
  always_comb begin
    overflow_d  = overflow_q;
    n_dropped_d = n_dropped_q;
    if (clr) begin
      overflow_d  = 1'b0;
      n_dropped_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (n_dropped_d != {SEQ_W{1'b1}}) begin
        n_dropped_d = n_dropped_d + SEQ_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      seq_q       <= '0;
      primed_q    <= 1'b0;
      overflow_q  <= 1'b0;
      n_dropped_q <= '0;
    end else begin
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      seq_q       <= seq_d;
      primed_q    <= primed_d;
      overflow_q  <= overflow_d;
      n_dropped_q <= n_dropped_d;
    end
  end

  assign o_valid        = (level_q != '0);
  assign o_level        = level_q;
  assign o_overflow     = overflow_q;
  assign o_nDropped     = n_dropped_q;
  assign o_countX       = rdata[DATA_W-1:0];
  assign o_countY       = rdata[2*DATA_W-1:DATA_W];
  assign o_countIsect   = rdata[3*DATA_W-1:2*DATA_W];
  assign o_countSymdiff = rdata[4*DATA_W-1:3*DATA_W];
  assign o_seq          = rdata[EntryW-1:4*DATA_W];

endmodule

// File: tb/tb_corr_window_buffer.sv
// Directed bench for corr_window_buffer at default widths (DATA_W=8, DEPTH_W=2, SEQ_W=8).
module tb_corr_window_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cg = 1'b1;
  logic       tupd = 1'b0;
  logic [7:0] cx = '0, cy = '0, cis = '0, csd = '0;
  logic       valid;
  logic       ready = 1'b0;
  logic [7:0] ox, oy, ois, osd, oseq, ndrop;
  logic [2:0] level;
  logic       ovf;
  logic       clr_ovf = 1'b0;

  int tests = 0;
  int fails = 0;

  corr_window_buffer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_cg           (cg),
    .i_tUpdate      (tupd),
    .i_countX       (cx),
    .i_countY       (cy),
    .i_countIsect   (cis),
    .i_countSymdiff (csd),
    .o_valid        (valid),
    .i_ready        (ready),
    .o_countX       (ox),
    .o_countY       (oy),
    .o_countIsect   (ois),
    .o_countSymdiff (osd),
    .o_seq          (oseq),
    .o_level        (level),
    .o_overflow     (ovf),
    .o_nDropped     (ndrop),
    .i_clrOverflow  (clr_ovf)
  );

  always #5 clk = ~clk;

  // One clock with the given strobe/ready/clear; outputs are settled #1 after the edge.
  task automatic step(input logic tu, input logic rdy, input logic clr,
                      input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] is, input logic [7:0] sd);
    tupd = tu; ready = rdy; clr_ovf = clr;
    cx = x; cy = y; cis = is; csd = sd;
    @(posedge clk); #1;
    tupd = 1'b0; ready = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", valid); end
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL reset_level got %0d want 0", level); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %0b want 0", ovf); end
    tests++; if (ndrop !== 8'd0) begin fails++; $display("FAIL reset_ndrop got %0d want 0", ndrop); end
  endtask

  task automatic test_prime_and_first();
    step(1, 0, 0, 8'd3, 8'd4, 8'd1, 8'd5);
    tests++; if (valid !== 1'b0 || level !== 3'd0) begin
      fails++; $display("FAIL prime_discard got valid=%0b level=%0d want 0/0", valid, level);
    end
    step(1, 0, 0, 8'd7, 8'd2, 8'd2, 8'd5);
    tests++; if (valid !== 1'b1 || level !== 3'd1) begin
      fails++; $display("FAIL first_push got valid=%0b level=%0d want 1/1", valid, level);
    end
    tests++; if ({oseq, ox, oy, ois, osd} !== {8'd0, 8'd7, 8'd2, 8'd2, 8'd5}) begin
      fails++; $display("FAIL first_entry got seq=%0d %0d,%0d,%0d,%0d want 0 7,2,2,5",
                        oseq, ox, oy, ois, osd);
    end
    step(0, 1, 0, 8'd0, 8'd0, 8'd0, 8'd0);
    tests++; if (valid !== 1'b0 || level !== 3'd0) begin
      fails++; $display("FAIL first_pop got valid=%0b level=%0d want 0/0", valid, level);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_seq;
    do_reset();
    step(1, 0, 0, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 8'(10 + i), 8'(20 + i), 8'(30 + i), 8'(40 + i));
    end
    tests++; if (level !== 3'd4) begin fails++; $display("FAIL ovf_level got %0d want 4", level); end
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_flag got %0b want 1", ovf); end
    tests++; if (ndrop !== 8'd2) begin fails++; $display("FAIL ovf_ndrop got %0d want 2", ndrop); end
    for (int k = 0; k < 4; k++) begin
      exp_seq = 8'(k);
      tests++; if (oseq !== exp_seq || ox !== 8'(10 + k) || osd !== 8'(40 + k)) begin
        fails++; $display("FAIL ovf_pop%0d got seq=%0d x=%0d sd=%0d want %0d/%0d/%0d",
                          k, oseq, ox, osd, k, 10 + k, 40 + k);
      end
      step(0, 1, 0, 8'd0, 8'd0, 8'd0, 8'd0);
    end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL ovf_drained got %0b want 0", valid); end
    step(1, 0, 0, 8'd50, 8'd51, 8'd52, 8'd53);
    tests++; if (oseq !== 8'd6 || ox !== 8'd50) begin
      fails++; $display("FAIL seq_gap got seq=%0d x=%0d want 6/50", oseq, ox);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_seq;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 8'(51 + i), 8'd0, 8'd0, 8'd0);
    end
    tests++; if (level !== 3'd4) begin fails++; $display("FAIL refill_level got %0d want 4", level); end
    step(1, 1, 0, 8'd60, 8'd61, 8'd62, 8'd63);
    tests++; if (level !== 3'd4 || ndrop !== 8'd2) begin
      fails++; $display("FAIL full_pp got level=%0d ndrop=%0d want 4/2", level, ndrop);
    end
    tests++; if (oseq !== 8'd7) begin fails++; $display("FAIL full_pp_head got %0d want 7", oseq); end
    for (int k = 0; k < 4; k++) begin
      exp_seq = 8'(7 + k);
      tests++; if (oseq !== exp_seq) begin
        fails++; $display("FAIL full_pp_pop%0d got seq=%0d want %0d", k, oseq, exp_seq);
      end
      if (k == 3) begin
        tests++; if ({ox, oy, ois, osd} !== {8'd60, 8'd61, 8'd62, 8'd63}) begin
          fails++; $display("FAIL full_pp_tail got %0d,%0d,%0d,%0d want 60,61,62,63",
                            ox, oy, ois, osd);
        end
      end
      step(0, 1, 0, 8'd0, 8'd0, 8'd0, 8'd0);
    end
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL full_pp_drain got %0d want 0", level); end
  endtask

  task automatic test_clock_gate();
    step(1, 0, 0, 8'd70, 8'd71, 8'd72, 8'd73);
    cg = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 8'd99, 8'd99, 8'd99, 8'd99);
    end
    tests++; if (valid !== 1'b1 || level !== 3'd1 || oseq !== 8'd11 || ox !== 8'd70) begin
      fails++; $display("FAIL cg_hold got v=%0b lvl=%0d seq=%0d x=%0d want 1/1/11/70",
                        valid, level, oseq, ox);
    end
    tests++; if (ovf !== 1'b1 || ndrop !== 8'd2) begin
      fails++; $display("FAIL cg_hold_ovf got ovf=%0b ndrop=%0d want 1/2", ovf, ndrop);
    end
    cg = 1'b1;
    step(1, 0, 0, 8'd80, 8'd0, 8'd0, 8'd0);
    step(0, 1, 0, 8'd0, 8'd0, 8'd0, 8'd0);
    tests++; if (oseq !== 8'd12 || ox !== 8'd80 || level !== 3'd1) begin
      fails++; $display("FAIL cg_seq got seq=%0d x=%0d lvl=%0d want 12/80/1", oseq, ox, level);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 8'd81, 8'd0, 8'd0, 8'd0);
    step(1, 0, 0, 8'd82, 8'd0, 8'd0, 8'd0);
    tests++; if (level !== 3'd3) begin fails++; $display("FAIL pre_rst_level got %0d want 3", level); end
    #2 rst = 1'b1;
    #1;
    tests++; if (valid !== 1'b0 || level !== 3'd0 || ovf !== 1'b0 || ndrop !== 8'd0) begin
      fails++; $display("FAIL async_rst got v=%0b lvl=%0d ovf=%0b nd=%0d want 0/0/0/0",
                        valid, level, ovf, ndrop);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    step(1, 0, 0, 8'd1, 8'd1, 8'd1, 8'd1);
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL rst_prime got %0b want 0", valid); end
    step(1, 0, 0, 8'd2, 8'd2, 8'd2, 8'd2);
    tests++; if (valid !== 1'b1 || oseq !== 8'd0 || ox !== 8'd2) begin
      fails++; $display("FAIL rst_restart got v=%0b seq=%0d x=%0d want 1/0/2", valid, oseq, ox);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 8'd3, 8'd0, 8'd0, 8'd0);
    end
    for (int i = 0; i < 255; i++) begin
      step(1, 0, 0, 8'd4, 8'd0, 8'd0, 8'd0);
    end
    tests++; if (ndrop !== 8'hFF || ovf !== 1'b1) begin
      fails++; $display("FAIL sat_reach got nd=%0d ovf=%0b want 255/1", ndrop, ovf);
    end
    step(1, 0, 0, 8'd5, 8'd0, 8'd0, 8'd0);
    step(1, 0, 0, 8'd5, 8'd0, 8'd0, 8'd0);
    tests++; if (ndrop !== 8'hFF) begin fails++; $display("FAIL sat_hold got %0d want 255", ndrop); end
    step(0, 0, 1, 8'd0, 8'd0, 8'd0, 8'd0);
    tests++; if (ndrop !== 8'd0 || ovf !== 1'b0) begin
      fails++; $display("FAIL clr got nd=%0d ovf=%0b want 0/0", ndrop, ovf);
    end
    step(1, 0, 1, 8'd6, 8'd0, 8'd0, 8'd0);
    tests++; if (ndrop !== 8'd1 || ovf !== 1'b1 || level !== 3'd4) begin
      fails++; $display("FAIL clr_drop got nd=%0d ovf=%0b lvl=%0d want 1/1/4", ndrop, ovf, level);
    end
  endtask

  initial begin
    test_reset();
    test_prime_and_first();
    test_overflow();
    test_full_push_pop();
    test_clock_gate();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/corr_window_buffer.md
CORR_WINDOW_BUFFER -- requirements
Module: corr_window_buffer

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of each count field.
REQ-002 Parameter DEPTH_W, default 2, SHALL set the FIFO depth to 2**DEPTH_W entries.
REQ-003 Parameter SEQ_W, default 8, SHALL set the width of the window sequence number and of the drop counter.
REQ-004 i_clk  in  1  SHALL be the single clock.
REQ-005 i_rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-006 i_cg  in  1  SHALL be the clock-gate enable; when 0, all state SHALL hold.
REQ-007 i_tUpdate  in  1  SHALL be the window-boundary strobe shared with the upstream counter stage.
REQ-008 i_countX, i_countY, i_countIsect, i_countSymdiff  in  DATA_W each  SHALL be the live window counts from the upstream counter stage.
REQ-009 o_valid  out  1  SHALL mean an entry is presented.
REQ-010 i_ready  in  1  SHALL mean the consumer accepts the entry.
REQ-011 o_countX, o_countY, o_countIsect, o_countSymdiff  out  DATA_W each  SHALL be the presented entry's counts.
REQ-012 o_seq  out  SEQ_W  SHALL be the presented entry's window sequence number.
REQ-013 o_level  out  DEPTH_W+1  SHALL be the current FIFO occupancy.
REQ-014 o_overflow  out  1  SHALL be a sticky flag indicating a snapshot was dropped.
REQ-015 o_nDropped  out  SEQ_W  SHALL be the saturating count of dropped snapshots.
REQ-016 i_clrOverflow  in  1  SHALL clear o_overflow and o_nDropped.

Function
REQ-017 Snapshot event SHALL be i_cg=1 and i_tUpdate=1; the four count inputs sampled that cycle (final counts of the closing window) SHALL form the entry.
REQ-018 A window sequence counter SHALL increment by 1 (mod 2**SEQ_W) on every snapshot event after priming, whether the entry is stored or dropped, and the pre-increment value SHALL be stored with the entry, so drops appear as o_seq gaps.
REQ-019 The first snapshot event after reset SHALL be discarded (partial window): no push, no drop, no seq increment; it SHALL set the primed flag.
REQ-020 A pop SHALL occur when i_cg=1, o_valid=1 and i_ready=1.
REQ-021 The FIFO SHALL be first-word-fall-through: o_valid = (level != 0); outputs SHALL reflect the head entry whenever o_valid=1.
REQ-022 Push-to-o_valid latency SHALL be 1 cycle when empty.
REQ-023 A push and a pop in the same cycle SHALL leave the level unchanged, including when full.
REQ-024 A push when full without a simultaneous pop SHALL drop the entry, set o_overflow and increment o_nDropped, saturating at all-ones.
REQ-025 Pointers SHALL wrap modulo 2**DEPTH_W; full is level = 2**DEPTH_W.
REQ-026 i_clrOverflow together with a drop in the same cycle SHALL result in o_overflow=1 and o_nDropped=1.
REQ-027 o_valid SHALL never deassert without a pop; head data SHALL be stable while o_valid=1 and i_ready=0.

Reset
REQ-028 Reset SHALL clear the level, pointers, seq counter, primed flag, o_overflow and o_nDropped to 0; o_valid SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries immediately; storage RAM contents need not be cleared.

Structure
REQ-030 The package corr_pkg SHALL hold the default widths and the packed entry layout {seq, countSymdiff, countIsect, countY, countX}, with width constant CORR_ENTRY_W.
REQ-031 Storage SHALL be a sub-module, corr_window_fifo_mem: 2**DEPTH_W x entry width, with one registered write port and one asynchronous read port.

Verification
REQ-032 Reset, then strobes with counts 3,4,1,5 and then 7,2,2,5 -> first strobe discarded; one entry {seq=0, 7,2,2,5}, o_valid=1 on the next cycle.
REQ-033 Hold i_ready=0 and issue 6 snapshots with DEPTH_W=2 -> o_level=4, o_overflow=1, o_nDropped=2; subsequent pops yield seq 0..3, the next snapshot stores seq=6.
REQ-034 While full, assert i_ready=1 concurrently with a snapshot -> level stays 4, o_nDropped unchanged, new tail entry present.
REQ-035 i_cg=0 with i_tUpdate=1 and i_ready=1 -> no push, no pop, all outputs unchanged.
REQ-036 Assert reset with 3 entries queued, then release -> o_valid=0, o_level=0, o_seq restarts at 0 after a new priming strobe.
REQ-037 Force o_nDropped to all-ones via drops, drop again -> value holds at all-ones; i_clrOverflow -> 0.
